fsm_1100_tx: RTL and testbench

FSM_1100_TX -- requirements
Module: fsm_1100_tx

---
 rtl/fsm_1100_tx.sv | 136 +++++++++++++
 tb/tb_fsm_1100_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_1100_tx.sv
// fsm_1100_tx: serial frame transmitter.
// Each accepted payload word goes out as a frame: a 4-bit sync field 1,1,0,0
// followed by the payload MSB first. A 1 is stuffed after every 1,1,0 seen in
// the payload phase, so that 1,1,0,0 only ever appears as the sync field.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   data_in    : payload word, latched on a transfer
//   data_valid : data_in is presented for transmission
//   data_ready : block accepts data_in this cycle (IDLE only, low while rst)
//   bit_out    : serial line bit
//   bit_valid  : bit_out carries a frame bit this cycle
//   sync_start : one-cycle pulse on the first sync bit
//   frame_done : one-cycle pulse on the last bit of a frame (payload or stuffed)
module fsm_1100_tx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              sync_start,
  output logic              frame_done
);

  localparam int unsigned CW = $clog2(DATA_W + 1);
  localparam int unsigned IW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_cnt_q, sync_cnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;      // payload bits already sent
  logic [2:0]        hist_q, hist_d;    // last three payload-phase bits, newest in [0]
  logic [DATA_W-1:0] payload_q, payload_d;

  logic [IW-1:0]     idx;
  logic [CW-1:0]     cnt_inc;
  logic              pay_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_cnt_q <= '0;
      cnt_q      <= '0;
      hist_q     <= '0;
      payload_q  <= '0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      cnt_q      <= cnt_d;
      hist_q     <= hist_d;
      payload_q  <= payload_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    cnt_d      = cnt_q;
    hist_d     = hist_q;
    payload_d  = payload_q;
    data_ready = 1'b0;
    bit_out    = 1'b0;
    bit_valid  = 1'b0;
    sync_start = 1'b0;
    frame_done = 1'b0;
    // Payload is indexed rather than shifted so the latched word stays intact.
    idx        = IW'(DATA_W - 1) - cnt_q[IW-1:0];
    cnt_inc    = cnt_q + CW'(1);
    pay_bit    = payload_q[idx];

    unique case (state_q)
      IDLE: begin
        // Reset forces state to IDLE; gate ready so it stays low during reset.
        data_ready = ~rst;
        if (data_valid) begin
          payload_d  = data_in;
          sync_cnt_d = '0;
          state_d    = SYNC;
        end
      end

      SYNC: begin
        bit_valid  = 1'b1;
        bit_out    = ~sync_cnt_q[1];   // 1,1,0,0
        sync_start = (sync_cnt_q == 2'd0);
        sync_cnt_d = sync_cnt_q + 2'd1;
        if (sync_cnt_q == 2'd3) begin
          cnt_d   = '0;
          hist_d  = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        bit_valid = 1'b1;
        bit_out   = pay_bit;
        cnt_d     = cnt_inc;
        hist_d    = {hist_q[1:0], pay_bit};
        // Stuff check precedes the end-of-payload check so a payload ending
        // in 1,1,0 still gets its trailing stuffed 1.
        if ({hist_q[1:0], pay_bit} == 3'b110) begin
          state_d = STUFF;
        end else if (cnt_inc == CW'(DATA_W)) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end

      STUFF: begin
        bit_valid = 1'b1;
        bit_out   = 1'b1;
        hist_d    = {hist_q[1:0], 1'b1};
        if (cnt_q == CW'(DATA_W)) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = DATA;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fsm_1100_tx.sv
// Testbench for fsm_1100_tx (DATA_W=8): directed vector table, data_valid held
// high, mid-frame reset, and random frames against a rule-based frame model.
// A 1100 detector runs over every valid line bit and must fire exactly once
// per frame, on the last sync bit.
module tb_fsm_1100_tx;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic          bit_out;
  logic          bit_valid;
  logic          sync_start;
  logic          frame_done;

  fsm_1100_tx #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .sync_start (sync_start),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit   exp_q[$];
  bit   got_q[$];
  logic [3:0] det_w = '0;
  int         det_n = 0;

  typedef struct {
    logic [7:0]  d;
    int          len;
    logic [15:0] bits;   // bit len-1 is the first line bit
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Line-level 1100 detector over valid bits; returns 1 on a hit.
  function automatic bit det_push(input bit b);
    det_w = {det_w[2:0], b};
    if (det_n < 4) det_n++;
    return (det_n >= 4) && (det_w == 4'b1100);
  endfunction

  function automatic void det_clear();
    det_w = '0;
    det_n = 0;
  endfunction

  // Frame model from the rules: sync field, payload MSB first, and a 1 appended
  // whenever the last three payload-phase line bits read 1,1,0.
  function automatic void build_exp(input logic [7:0] d);
    int n;
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = DW - 1; i >= 0; i--) begin
      exp_q.push_back(d[i]);
      n = exp_q.size();
      if (n - 4 >= 3 && exp_q[n-3] == 1'b1 && exp_q[n-2] == 1'b1 && exp_q[n-1] == 1'b0)
        exp_q.push_back(1'b1);
    end
  endfunction

  // Send one frame of d and compare the line against exp_q.
  task automatic run_frame(input logic [7:0] d, input string tag);
    int cyc;
    int seq_bad, ss_bad, fd_bad, rdy_bad, hits, hit_pos;
    @(negedge clk);
    check({tag, "_ready_idle"}, int'(data_ready), 1);
    data_valid = 1'b1;
    data_in    = d;
    @(negedge clk);
    data_valid = 1'b0;
    got_q.delete();
    cyc = 0; seq_bad = 0; ss_bad = 0; fd_bad = 0; rdy_bad = 0; hits = 0; hit_pos = -1;
    while (bit_valid && cyc < 60) begin
      if (got_q.size() >= exp_q.size() || bit_out != exp_q[got_q.size()]) seq_bad++;
      if (sync_start != (got_q.size() == 0)) ss_bad++;
      if (frame_done != (got_q.size() == exp_q.size() - 1)) fd_bad++;
      if (data_ready) rdy_bad++;
      if (det_push(bit_out)) begin
        hits++;
        hit_pos = got_q.size();
      end
      got_q.push_back(bit_out);
      data_valid = 1'($urandom_range(0, 1));   // must be ignored mid-frame
      data_in    = 8'($urandom);
      @(negedge clk);
      cyc++;
    end
    data_valid = 1'b0;
    check({tag, "_timeout"}, int'(cyc >= 60), 0);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    check({tag, "_bits"}, seq_bad, 0);
    check({tag, "_sync_start"}, ss_bad, 0);
    check({tag, "_frame_done"}, fd_bad, 0);
    check({tag, "_ready_busy"}, rdy_bad, 0);
    check({tag, "_det_hits"}, hits, 1);
    check({tag, "_det_pos"}, hit_pos, 3);
    check({tag, "_idle_out"}, int'({bit_out, bit_valid}), 0);
  endtask

  initial begin
    int ready_n, sync_n, done_n, hits, ready_busy;

    tbl[0] = '{8'h00, 12, 16'b1100_0000_0000};
    tbl[1] = '{8'hC0, 13, 16'b1_1001_1010_0000};
    tbl[2] = '{8'hDB, 14, 16'b11_0011_0111_0111};
    tbl[3] = '{8'h06, 13, 16'b1_1000_0000_1101};

    rst        = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    #1;
    check("rst_outputs", int'({data_ready, bit_out, bit_valid, sync_start, frame_done}), 0);
    @(negedge clk);
    @(negedge clk);
    check("rst_ready_held", int'(data_ready), 0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", int'(data_ready), 1);

    // Directed table
    for (int unsigned i = 0; i < 4; i++) begin
      exp_q.delete();
      for (int b = 0; b < tbl[i].len; b++) exp_q.push_back(tbl[i].bits[tbl[i].len - 1 - b]);
      run_frame(tbl[i].d, $sformatf("vec%0d", i));
    end

    // data_valid held high: three frames of 0x00 occupy exactly 3*(12+1) cycles
    ready_n = 0; sync_n = 0; done_n = 0; hits = 0; ready_busy = 0;
    data_in    = 8'h00;
    data_valid = 1'b1;
    for (int c = 0; c < 39; c++) begin
      if (data_ready) begin
        ready_n++;
        if (bit_valid) ready_busy++;
      end
      if (sync_start) sync_n++;
      if (frame_done) done_n++;
      if (bit_valid && det_push(bit_out)) hits++;
      @(negedge clk);
    end
    data_valid = 1'b0;
    check("cont_ready_pulses", ready_n, 3);
    check("cont_sync_starts", sync_n, 3);
    check("cont_frame_dones", done_n, 3);
    check("cont_det_hits", hits, 3);
    check("cont_ready_while_busy", ready_busy, 0);

    // Reset at payload bit 3 of 0xFF
    @(negedge clk);
    data_in    = 8'hFF;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_mid_frame_valid", int'(bit_valid), 1);
    rst = 1'b1;
    det_clear();
    #1;
    check("abort_async_outputs", int'({data_ready, bit_out, bit_valid, sync_start, frame_done}), 0);
    @(negedge clk);
    check("abort_held_outputs", int'({data_ready, bit_valid, frame_done}), 0);
    rst = 1'b0;
    #1;
    check("abort_release_ready", int'(data_ready), 1);
    build_exp(8'h00);
    run_frame(8'h00, "after_abort");

    // Random frames with random idle gaps
    for (int unsigned i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      build_exp(d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_frame(d, $sformatf("rnd%0d_%02h", i, d));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
